dfdiv_norm: RTL and testbench

Post-divide normalizer/rounder for the decimal float divide path. It consumes the 2N-digit BCD quotient, the leading-zero digit count, and the remainder from the BCD mantissa divider. It shifts the quotient left one digit per clock until normalized, rounds to N digits with a digit-serial BCD incrementer, adjusts the exponent, and presents the significand to the decimal float packer.

---
 rtl/dfpu_pkg.sv | 31 +++
 rtl/dfround_dec.sv | 28 ++
 rtl/dfdiv_norm.sv | 194 +++++++++++++++++++
 tb/tb_dfdiv_norm.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dfpu_pkg.sv
// Shared decimal-FPU types: rounding modes and the normalizer FSM states.
// The divider, rounders and packer all use these definitions.
package dfpu_pkg;

    typedef enum logic [2:0] {
        RM_HEVEN = 3'd0,
        RM_TZERO = 3'd1,
        RM_PINF  = 3'd2,
        RM_NINF  = 3'd3,
        RM_HAWAY = 3'd4
    } rm_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RND   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Encodings 5..7 are reserved and behave as round-toward-zero.
    function automatic rm_e rm_decode(input logic [2:0] rm);
        case (rm)
            3'd0:    rm_decode = RM_HEVEN;
            3'd2:    rm_decode = RM_PINF;
            3'd3:    rm_decode = RM_NINF;
            3'd4:    rm_decode = RM_HAWAY;
            default: rm_decode = RM_TZERO;
        endcase
    endfunction

endpackage

// File: rtl/dfround_dec.sv
// Combinational round-increment decision for decimal rounding.
// Shared by the divide, add and multiply rounders.
module dfround_dec
    import dfpu_pkg::*;
(
    input  logic [3:0] g_i,
    input  logic       sticky_i,
    input  logic       lsd_odd_i,
    input  logic       sgn_i,
    input  rm_e        rm_i,
    output logic       inc_o
);

    logic inexact;
    assign inexact = (g_i != 4'd0) | sticky_i;

    always_comb begin
        inc_o = 1'b0;
        case (rm_i)
            RM_HEVEN: inc_o = (g_i > 4'd5) | ((g_i == 4'd5) & (sticky_i | lsd_odd_i));
            RM_HAWAY: inc_o = (g_i >= 4'd5);
            RM_PINF:  inc_o = inexact & ~sgn_i;
            RM_NINF:  inc_o = inexact & sgn_i;
            default:  inc_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dfdiv_norm.sv
// Post-divide normalizer/rounder: digit-serial left shift until normalized,
// then digit-serial BCD increment, exponent adjust, result held until next ld.
module dfdiv_norm
    import dfpu_pkg::*;
#(
    parameter int N  = 33,
    parameter int EW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ld,
    input  logic [8*N-1:0] qin,
    input  logic [4*N-1:0] rin,
    input  logic [7:0]     lzcnt,
    input  logic [EW-1:0]  exp_in,
    input  logic           sgn,
    input  logic [2:0]     rm,
    output logic [4*N-1:0] sig,
    output logic [EW-1:0]  exp_out,
    output logic           inexact,
    output logic           zero,
    output logic           done
);

    localparam int         IW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0] CNT_MAX = 8'(2 * N - 1);

    state_e           state_q, state_d;
    logic [8*N-1:0]   quo_q, quo_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [EW-1:0]    exp_q, exp_d;
    logic             sticky0_q, sticky0_d;
    logic             inx_q, inx_d;
    logic             sgn_q, sgn_d;
    rm_e              rm_q, rm_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [4*N-1:0]   sig_q, sig_d;
    logic [EW-1:0]    exp_out_q, exp_out_d;
    logic             inexact_q, inexact_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [4*N-1:0]   top;
    logic [4*N-1:0]   top_w;
    logic [3:0]       guard;
    logic [3:0]       cur_dig;
    logic             ev_sticky;
    logic             ev_inexact;
    logic             round_inc;

    assign top        = quo_q[8*N-1:4*N];
    assign guard      = quo_q[4*N-1:4*N-4];
    assign ev_sticky  = sticky0_q | (|quo_q[4*N-5:0]);
    assign ev_inexact = (guard != 4'd0) | ev_sticky;
    assign cur_dig    = top[{idx_q, 2'b00} +: 4];

    dfround_dec u_round (
        .g_i       (guard),
        .sticky_i  (ev_sticky),
        .lsd_odd_i (top[0]),
        .sgn_i     (sgn_q),
        .rm_i      (rm_q),
        .inc_o     (round_inc)
    );

    always_comb begin
        state_d   = state_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        sticky0_d = sticky0_q;
        inx_d     = inx_q;
        sgn_d     = sgn_q;
        rm_d      = rm_q;
        idx_d     = idx_q;
        sig_d     = sig_q;
        exp_out_d = exp_out_q;
        inexact_d = inexact_q;
        zero_d    = zero_q;
        done_d    = done_q;
        top_w     = top;

        case (state_q)
            ST_SHIFT: begin
                if (cnt_q != 8'd0) begin
                    quo_d = {quo_q[8*N-5:0], 4'h0};
                    cnt_d = cnt_q - 8'd1;
                    exp_d = exp_q - EW'(1);
                end else if (round_inc) begin
                    state_d = ST_RND;
                    idx_d   = '0;
                    inx_d   = ev_inexact;
                end else begin
                    state_d   = ST_DONE;
                    sig_d     = top;
                    exp_out_d = exp_q;
                    inexact_d = ev_inexact;
                    zero_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            ST_RND: begin
                // Working significand lives in the upper quotient half so the
                // visible outputs only move on entry to DONE.
                if (cur_dig == 4'd9) begin
                    top_w[{idx_q, 2'b00} +: 4] = 4'd0;
                    if (idx_q == IW'(N - 1)) begin
                        state_d   = ST_DONE;
                        sig_d     = {4'h1, {(4*N-4){1'b0}}};
                        exp_out_d = exp_q + EW'(1);
                        inexact_d = inx_q;
                        zero_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        idx_d               = idx_q + IW'(1);
                        quo_d[8*N-1:4*N]    = top_w;
                    end
                end else begin
                    top_w[{idx_q, 2'b00} +: 4] = cur_dig + 4'd1;
                    state_d   = ST_DONE;
                    sig_d     = top_w;
                    exp_out_d = exp_q;
                    inexact_d = inx_q;
                    zero_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase

        // ld wins over whatever the FSM was doing.
        if (ld) begin
            quo_d     = qin;
            exp_d     = exp_in;
            sgn_d     = sgn;
            rm_d      = rm_decode(rm);
            cnt_d     = (lzcnt > CNT_MAX) ? CNT_MAX : lzcnt;
            sticky0_d = (rin != '0);
            idx_d     = '0;
            done_d    = 1'b0;
            if (qin == '0) begin
                state_d   = ST_DONE;
                zero_d    = 1'b1;
                sig_d     = '0;
                exp_out_d = exp_in;
                inexact_d = (rin != '0);
            end else begin
                state_d = ST_SHIFT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            quo_q     <= '0;
            cnt_q     <= '0;
            exp_q     <= '0;
            sticky0_q <= 1'b0;
            inx_q     <= 1'b0;
            sgn_q     <= 1'b0;
            rm_q      <= RM_HEVEN;
            idx_q     <= '0;
            sig_q     <= '0;
            exp_out_q <= '0;
            inexact_q <= 1'b0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            sticky0_q <= sticky0_d;
            inx_q     <= inx_d;
            sgn_q     <= sgn_d;
            rm_q      <= rm_d;
            idx_q     <= idx_d;
            sig_q     <= sig_d;
            exp_out_q <= exp_out_d;
            inexact_q <= inexact_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
        end
    end

    assign sig     = sig_q;
    assign exp_out = exp_out_q;
    assign inexact = inexact_q;
    assign zero    = zero_q;
    assign done    = done_q;

endmodule

// File: tb/tb_dfdiv_norm.sv
// Self-checking bench for dfdiv_norm with N=4, EW=16: vector table plus
// hand-written abort, async-reset and hold sequences.
module tb_dfdiv_norm;

    localparam int N  = 4;
    localparam int EW = 16;

    logic           clk;
    logic           rst_n;
    logic           ld;
    logic [8*N-1:0] qin;
    logic [4*N-1:0] rin;
    logic [7:0]     lzcnt;
    logic [EW-1:0]  exp_in;
    logic           sgn;
    logic [2:0]     rm;
    logic [4*N-1:0] sig;
    logic [EW-1:0]  exp_out;
    logic           inexact;
    logic           zero;
    logic           done;

    dfdiv_norm #(.N(N), .EW(EW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (ld),
        .qin     (qin),
        .rin     (rin),
        .lzcnt   (lzcnt),
        .exp_in  (exp_in),
        .sgn     (sgn),
        .rm      (rm),
        .sig     (sig),
        .exp_out (exp_out),
        .inexact (inexact),
        .zero    (zero),
        .done    (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] qin;
        logic [15:0] rin;
        logic [7:0]  lz;
        logic [15:0] ein;
        logic        sgn;
        logic [2:0]  rm;
        logic [15:0] sig;
        logic [15:0] eout;
        logic        inx;
        logic        zr;
        int          lat;
    } vec_t;

    vec_t vt[$];

    logic [33:0] exp_q[$];
    int          lat_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic add(input logic [31:0] q, input logic [15:0] r, input logic [7:0] lz,
                       input logic [15:0] ei, input logic s, input logic [2:0] m,
                       input logic [15:0] es, input logic [15:0] ee, input logic ix,
                       input logic ez, input int l);
        vec_t v;
        v.qin = q; v.rin = r; v.lz = lz; v.ein = ei; v.sgn = s; v.rm = m;
        v.sig = es; v.eout = ee; v.inx = ix; v.zr = ez; v.lat = l;
        vt.push_back(v);
    endtask

    // driver: ld is sampled at e0, then data inputs are scrambled
    task automatic drive_ld(input logic [31:0] q, input logic [15:0] r, input logic [7:0] lz,
                            input logic [15:0] ei, input logic s, input logic [2:0] m);
        @(negedge clk);
        ld = 1'b1; qin = q; rin = r; lzcnt = lz; exp_in = ei; sgn = s; rm = m;
        @(posedge clk);
        #1;
        ld     = 1'b0;
        qin    = $urandom();
        rin    = 16'($urandom());
        lzcnt  = 8'($urandom_range(0, 255));
        exp_in = 16'($urandom());
        sgn    = 1'($urandom_range(0, 1));
        rm     = 3'($urandom_range(0, 7));
    endtask

    task automatic push_exp(input logic [15:0] es, input logic [15:0] ee, input logic ix,
                            input logic ez, input int l);
        exp_q.push_back({es, ee, ix, ez});
        lat_q.push_back(l);
    endtask

    // scoreboard: called at e0+1, counts edges until done, then pops
    task automatic wait_result(input string name);
        int          k;
        logic [33:0] e;
        int          l;
        chk({name, "_done_clr"}, 64'(done), 64'(0));
        k = 0;
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (exp_q.size() == 0) begin
            chk({name, "_sb_empty"}, 64'(1), 64'(0));
        end else begin
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            chk({name, "_latency"}, 64'(k), 64'(l));
            chk({name, "_result"}, 64'({sig, exp_out, inexact, zero}), 64'(e));
        end
    endtask

    initial begin
        rst_n = 1'b0; ld = 1'b0; qin = '0; rin = '0; lzcnt = '0;
        exp_in = '0; sgn = 1'b0; rm = '0;

        //    qin           rin     lz     ein      s  rm  sig      eout     ix zr lat
        add(32'h0333_3333, 16'h1, 8'd1,  16'h0000, 0, 0, 16'h3333, 16'hFFFF, 1, 0, 2);
        add(32'h9999_9500, 16'h0, 8'd0,  16'h0000, 0, 0, 16'h1000, 16'h0001, 1, 0, 5);
        add(32'h1234_5000, 16'h0, 8'd0,  16'h0000, 0, 0, 16'h1234, 16'h0000, 1, 0, 1);
        add(32'h1234_5000, 16'h7, 8'd0,  16'h0000, 0, 0, 16'h1235, 16'h0000, 1, 0, 2);
        add(32'h1234_1000, 16'h0, 8'd0,  16'h0000, 1, 3, 16'h1235, 16'h0000, 1, 0, 2);
        add(32'h1234_1000, 16'h0, 8'd0,  16'h0000, 1, 2, 16'h1234, 16'h0000, 1, 0, 1);
        add(32'h1234_1000, 16'h0, 8'd0,  16'h0000, 1, 1, 16'h1234, 16'h0000, 1, 0, 1);
        add(32'h0000_0000, 16'h0, 8'd0,  16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 1);
        add(32'h0000_0000, 16'h5, 8'd3,  16'h0042, 0, 0, 16'h0000, 16'h0042, 1, 1, 1);
        add(32'h1234_5000, 16'h0, 8'd0,  16'h0000, 0, 4, 16'h1235, 16'h0000, 1, 0, 2);
        add(32'h1235_5000, 16'h0, 8'd0,  16'h0000, 0, 0, 16'h1236, 16'h0000, 1, 0, 2);
        add(32'h0000_0123, 16'h0, 8'd5,  16'h0000, 0, 0, 16'h1230, 16'hFFFB, 0, 0, 6);
        add(32'h0000_0123, 16'h3, 8'd5,  16'h0005, 0, 2, 16'h1231, 16'h0000, 1, 0, 7);
        add(32'h1234_9000, 16'h0, 8'd0,  16'h0000, 0, 6, 16'h1234, 16'h0000, 1, 0, 1);
        add(32'h1234_0000, 16'h0, 8'd0,  16'h0000, 0, 2, 16'h1234, 16'h0000, 0, 0, 1);
        add(32'h1299_9600, 16'h0, 8'd0,  16'h0000, 0, 0, 16'h1300, 16'h0000, 1, 0, 4);
        add(32'h0000_0001, 16'h0, 8'd200, 16'h0000, 0, 0, 16'h1000, 16'hFFF9, 0, 0, 8);
        add(32'h9999_9500, 16'h0, 8'd0,  16'h7FFF, 0, 4, 16'h1000, 16'h8000, 1, 0, 5);
        add(32'h9999_9999, 16'h0, 8'd0,  16'h0000, 1, 2, 16'h9999, 16'h0000, 1, 0, 1);

        #12;
        chk("reset_outputs", 64'({sig, exp_out, inexact, zero, done}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_done_low", 64'(done), 64'(0));

        foreach (vt[i]) begin
            drive_ld(vt[i].qin, vt[i].rin, vt[i].lz, vt[i].ein, vt[i].sgn, vt[i].rm);
            push_exp(vt[i].sig, vt[i].eout, vt[i].inx, vt[i].zr, vt[i].lat);
            wait_result($sformatf("v%0d", i));
        end

        // result and done hold while inputs toggle
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done", 64'(done), 64'(1));
        chk("hold_sig", 64'({sig, exp_out, inexact}), 64'({16'h9999, 16'h0000, 1'b1}));

        // ld mid-SHIFT: only the second operation may produce a result
        drive_ld(32'h0000_0123, 16'h0, 8'd5, 16'h0000, 0, 0);
        chk("abort_done_clr", 64'(done), 64'(0));
        repeat (2) @(posedge clk);
        drive_ld(32'h1234_5000, 16'h7, 8'd0, 16'h0000, 0, 0);
        push_exp(16'h1235, 16'h0000, 1'b1, 1'b0, 2);
        wait_result("abort");

        // asynchronous reset mid-SHIFT
        drive_ld(32'h0000_0123, 16'h0, 8'd5, 16'h0000, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 64'({sig, exp_out, inexact, zero, done}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_done_low", 64'({done, sig}), 64'(0));
        drive_ld(32'h0333_3333, 16'h1, 8'd1, 16'h0000, 0, 0);
        push_exp(16'h3333, 16'hFFFF, 1'b1, 1'b0, 2);
        wait_result("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
